// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter_pkg
// Purpose  : Shared encodings and widths for the memory bus arbiter slice.
//            Arbiter FSM state encoding, transaction owner encoding, and the
//            register/instruction-address bus widths.
// Macros   : none (MEM_ARB_TIMEOUT_EN is consumed by the arbiter top)
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_arbiter_pkg;

    localparam int REG_BUS_W       = 32;
    localparam int INST_ADDR_BUS_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } arb_owner_e;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_watchdog
// Purpose  : Transaction watchdog for the memory bus arbiter. Counts cycles
//            spent in REQ/WAIT, restarts on every new grant, and raises a
//            combinational expiry strobe in the last allowed cycle so the
//            arbiter can force completion on the following edge.
// Macros   : MEM_ARB_TIMEOUT_EN - module exists only when defined.
// Ports    : clk       in   clock
//            rst       in   asynchronous active-low reset
//            start_i   in   grant strobe (clears the counter)
//            active_i  in   arbiter is in REQ or WAIT
//            expire_o  out  TIMEOUT_CYCLES reached this cycle
// Revision : 1.0 - initial release
// ============================================================================
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_watchdog
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic active_i,
    output logic expire_o
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter holds the number of completed busy cycles, so it equals
    // TIMEOUT_CYCLES-1 during the TIMEOUT_CYCLES-th busy cycle.
    assign expire_o = active_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (active_i && !expire_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares one SRAM-like memory port between instruction fetch
//            (read-only) and the mem stage (load/store/LL/SC). One bus
//            transaction outstanding at a time; data has priority until it
//            has won STARVE_LIMIT grants in a row over a waiting fetch.
// Macros   : MEM_ARB_TIMEOUT_EN - enables the REQ/WAIT watchdog and bus_err_o.
// Ports    : clk, rst (async active-low)
//            inst_*  : fetch requester (req level, addr, ok pulse, rdata,
//                      stall) and flush_i to discard an in-flight fetch
//            data_*  : mem-stage requester (req level, we, sel, addr, wdata,
//                      ok pulse, rdata, stall)
//            bus_*   : bridge side (req/wr/wstrb/addr/wdata out, addr_ok,
//                      data_ok, rdata in, err pulse out)
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       inst_req_i,
    input  logic [INST_ADDR_BUS_W-1:0] inst_addr_i,
    output logic                       inst_ok_o,
    output logic [REG_BUS_W-1:0]       inst_rdata_o,
    output logic                       inst_stall_o,
    input  logic                       flush_i,

    input  logic                       data_req_i,
    input  logic                       data_we_i,
    input  logic [3:0]                 data_sel_i,
    input  logic [REG_BUS_W-1:0]       data_addr_i,
    input  logic [REG_BUS_W-1:0]       data_wdata_i,
    output logic                       data_ok_o,
    output logic [REG_BUS_W-1:0]       data_rdata_o,
    output logic                       data_stall_o,

    output logic                       bus_req_o,
    output logic                       bus_wr_o,
    output logic [3:0]                 bus_wstrb_o,
    output logic [REG_BUS_W-1:0]       bus_addr_o,
    output logic [REG_BUS_W-1:0]       bus_wdata_o,
    input  logic                       bus_addr_ok_i,
    input  logic                       bus_data_ok_i,
    input  logic [REG_BUS_W-1:0]       bus_rdata_i,
    output logic                       bus_err_o
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_e             state_q,      state_d;
    arb_owner_e             owner_q,      owner_d;
    logic [SC_W-1:0]        starve_q,     starve_d;
    logic                   discard_q,    discard_d;
    logic                   bus_req_q,    bus_req_d;
    logic                   bus_wr_q,     bus_wr_d;
    logic [3:0]             bus_wstrb_q,  bus_wstrb_d;
    logic [REG_BUS_W-1:0]   bus_addr_q,   bus_addr_d;
    logic [REG_BUS_W-1:0]   bus_wdata_q,  bus_wdata_d;
    logic                   inst_ok_q,    inst_ok_d;
    logic [REG_BUS_W-1:0]   inst_rdata_q, inst_rdata_d;
    logic                   data_ok_q,    data_ok_d;
    logic [REG_BUS_W-1:0]   data_rdata_q, data_rdata_d;
    logic                   bus_err_q,    bus_err_d;

    logic                   w_grant_data;
    logic                   w_grant_inst;
    logic                   w_busy;
    logic                   w_expire;
    logic                   w_finish;
    logic [REG_BUS_W-1:0]   w_fin_rdata;

    // Data wins unless it has already starved a waiting fetch STARVE_LIMIT times.
    assign w_grant_data = (state_q == ST_IDLE) && data_req_i &&
                          ((starve_q < SC_W'(STARVE_LIMIT)) || !inst_req_i);
    assign w_grant_inst = (state_q == ST_IDLE) && !w_grant_data && inst_req_i;
    assign w_busy       = (state_q == ST_REQ) || (state_q == ST_WAIT);

    // ------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------
`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .start_i  (w_grant_data || w_grant_inst),
        .active_i (w_busy),
        .expire_o (w_expire)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_expire         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_d     = starve_q;
        discard_d    = discard_q;
        bus_req_d    = bus_req_q;
        bus_wr_d     = bus_wr_q;
        bus_wstrb_d  = bus_wstrb_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        inst_ok_d    = 1'b0;
        inst_rdata_d = '0;
        data_ok_d    = 1'b0;
        data_rdata_d = '0;
        bus_err_d    = 1'b0;
        w_finish     = 1'b0;
        w_fin_rdata  = '0;

        // A redirect only ever discards a fetch; the bus side still completes.
        if ((state_q != ST_IDLE) && (owner_q == OWN_INST) && flush_i) begin
            discard_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_grant_data) begin
                    state_d     = ST_REQ;
                    owner_d     = OWN_DATA;
                    discard_d   = 1'b0;
                    bus_req_d   = 1'b1;
                    bus_wr_d    = data_we_i;
                    bus_wstrb_d = data_sel_i;
                    bus_addr_d  = data_addr_i;
                    bus_wdata_d = data_wdata_i;
                    if (!inst_req_i) begin
                        starve_d = '0;
                    end else if (starve_q != SC_W'(STARVE_LIMIT)) begin
                        starve_d = starve_q + SC_W'(1);
                    end
                end else if (w_grant_inst) begin
                    state_d     = ST_REQ;
                    owner_d     = OWN_INST;
                    discard_d   = flush_i;
                    bus_req_d   = 1'b1;
                    bus_wr_d    = 1'b0;
                    bus_wstrb_d = 4'b1111;
                    bus_addr_d  = inst_addr_i;
                    bus_wdata_d = '0;
                    starve_d    = '0;
                end else begin
                    starve_d = '0;
                end
            end

            ST_REQ: begin
                if (bus_addr_ok_i || w_expire) begin
                    bus_req_d   = 1'b0;
                    bus_wr_d    = 1'b0;
                    bus_wstrb_d = 4'b0000;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                end
                if (bus_addr_ok_i) begin
                    if (bus_data_ok_i) begin
                        w_finish    = 1'b1;
                        w_fin_rdata = bus_rdata_i;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (w_expire) begin
                    w_finish  = 1'b1;
                    bus_err_d = 1'b1;
                end
            end

            ST_WAIT: begin
                if (bus_data_ok_i) begin
                    w_finish    = 1'b1;
                    w_fin_rdata = bus_rdata_i;
                end else if (w_expire) begin
                    w_finish  = 1'b1;
                    bus_err_d = 1'b1;
                end
            end

            ST_DONE: begin
                state_d   = ST_IDLE;
                discard_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Completion: the ok pulse is registered, so it appears while in DONE.
        if (w_finish) begin
            state_d = ST_DONE;
            if (owner_q == OWN_DATA) begin
                data_ok_d    = 1'b1;
                data_rdata_d = w_fin_rdata;
            end else if (!(discard_q || flush_i)) begin
                inst_ok_d    = 1'b1;
                inst_rdata_d = w_fin_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_INST;
            starve_q     <= '0;
            discard_q    <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_wstrb_q  <= 4'b0000;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            inst_ok_q    <= 1'b0;
            inst_rdata_q <= '0;
            data_ok_q    <= 1'b0;
            data_rdata_q <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_q     <= starve_d;
            discard_q    <= discard_d;
            bus_req_q    <= bus_req_d;
            bus_wr_q     <= bus_wr_d;
            bus_wstrb_q  <= bus_wstrb_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_ok_q    <= inst_ok_d;
            inst_rdata_q <= inst_rdata_d;
            data_ok_q    <= data_ok_d;
            data_rdata_q <= data_rdata_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign inst_ok_o    = inst_ok_q;
    assign inst_rdata_o = inst_rdata_q;
    assign inst_stall_o = inst_req_i && !inst_ok_q;
    assign data_ok_o    = data_ok_q;
    assign data_rdata_o = data_rdata_q;
    assign data_stall_o = data_req_i && !data_ok_q;
    assign bus_req_o    = bus_req_q;
    assign bus_wr_o     = bus_wr_q;
    assign bus_wstrb_o  = bus_wstrb_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_wdata_o  = bus_wdata_q;
    assign bus_err_o    = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Directed self-checking bench for mem_bus_arbiter (default build,
//            MEM_ARB_TIMEOUT_EN undefined). Inputs change and outputs are
//            sampled on the falling clock edge; the DUT acts on rising edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req_i;
    logic [31:0] inst_addr_i;
    logic        inst_ok_o;
    logic [31:0] inst_rdata_o;
    logic        inst_stall_o;
    logic        flush_i;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_sel_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_ok_o;
    logic [31:0] data_rdata_o;
    logic        data_stall_o;
    logic        bus_req_o;
    logic        bus_wr_o;
    logic [3:0]  bus_wstrb_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_addr_ok_i;
    logic        bus_data_ok_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .STARVE_LIMIT   (4),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_req_i    (inst_req_i),
        .inst_addr_i   (inst_addr_i),
        .inst_ok_o     (inst_ok_o),
        .inst_rdata_o  (inst_rdata_o),
        .inst_stall_o  (inst_stall_o),
        .flush_i       (flush_i),
        .data_req_i    (data_req_i),
        .data_we_i     (data_we_i),
        .data_sel_i    (data_sel_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_ok_o     (data_ok_o),
        .data_rdata_o  (data_rdata_o),
        .data_stall_o  (data_stall_o),
        .bus_req_o     (bus_req_o),
        .bus_wr_o      (bus_wr_o),
        .bus_wstrb_o   (bus_wstrb_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_addr_ok_i (bus_addr_ok_i),
        .bus_data_ok_i (bus_data_ok_i),
        .bus_rdata_i   (bus_rdata_i),
        .bus_err_o     (bus_err_o)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        inst_req_i    = 1'b0;
        inst_addr_i   = '0;
        flush_i       = 1'b0;
        data_req_i    = 1'b0;
        data_we_i     = 1'b0;
        data_sel_i    = 4'b0000;
        data_addr_i   = '0;
        data_wdata_i  = '0;
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b0;
        bus_rdata_i   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        n_vec++;
        if ({bus_req_o, bus_wr_o, inst_ok_o, data_ok_o, bus_err_o} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {bus_req_o, bus_wr_o, inst_ok_o, data_ok_o, bus_err_o});
        end
        n_vec++;
        if ({bus_addr_o, bus_wdata_o, bus_wstrb_o} !== 68'h0) begin
            n_err++;
            $display("FAIL reset_bus: got addr %h wdata %h wstrb %b expected 0",
                     bus_addr_o, bus_wdata_o, bus_wstrb_o);
        end
        n_vec++;
        if ({inst_rdata_o, data_rdata_o} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h %h expected 0", inst_rdata_o, data_rdata_o);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_load();
        data_req_i  = 1'b1;
        data_sel_i  = 4'b1111;
        data_addr_i = 32'h1000_0004;
        #1;
        n_vec++;
        if (data_stall_o !== 1'b1) begin
            n_err++;
            $display("FAIL load_stall: got %b expected 1", data_stall_o);
        end
        tick(); // cycle 1: REQ
        n_vec++;
        if ({bus_req_o, bus_wr_o, bus_wstrb_o} !== 6'b10_1111 || bus_addr_o !== 32'h1000_0004) begin
            n_err++;
            $display("FAIL load_req: got req %b wr %b wstrb %b addr %h expected 1 0 1111 10000004",
                     bus_req_o, bus_wr_o, bus_wstrb_o, bus_addr_o);
        end
        bus_addr_ok_i = 1'b1;
        tick(); // cycle 2: WAIT
        n_vec++;
        if (bus_req_o !== 1'b0 || data_ok_o !== 1'b0) begin
            n_err++;
            $display("FAIL load_wait: got req %b ok %b expected 0 0", bus_req_o, data_ok_o);
        end
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b1;
        bus_rdata_i   = 32'hDEAD_BEEF;
        tick(); // cycle 3: DONE
        n_vec++;
        if (data_ok_o !== 1'b1 || data_rdata_o !== 32'hDEAD_BEEF || inst_ok_o !== 1'b0) begin
            n_err++;
            $display("FAIL load_done: got ok %b rdata %h iok %b expected 1 deadbeef 0",
                     data_ok_o, data_rdata_o, inst_ok_o);
        end
        n_vec++;
        if (data_stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL load_stall_done: got %b expected 0", data_stall_o);
        end
        clear_inputs();
        tick();
        n_vec++;
        if (data_ok_o !== 1'b0 || data_rdata_o !== 32'h0) begin
            n_err++;
            $display("FAIL load_pulse: got ok %b rdata %h expected 0 0", data_ok_o, data_rdata_o);
        end
    endtask

    task automatic test_simultaneous();
        inst_req_i   = 1'b1;
        inst_addr_i  = 32'h0000_0100;
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_sel_i   = 4'b0100;
        data_addr_i  = 32'h2000_0002;
        data_wdata_i = 32'h00AB_0000;
        tick(); // REQ for data
        n_vec++;
        if ({bus_req_o, bus_wr_o, bus_wstrb_o} !== 6'b11_0100 ||
            bus_addr_o !== 32'h2000_0002 || bus_wdata_o !== 32'h00AB_0000) begin
            n_err++;
            $display("FAIL simul_store: got req %b wr %b wstrb %b addr %h wdata %h expected 1 1 0100 20000002 00ab0000",
                     bus_req_o, bus_wr_o, bus_wstrb_o, bus_addr_o, bus_wdata_o);
        end
        bus_addr_ok_i = 1'b1;
        tick(); // WAIT
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b1;
        tick(); // DONE
        n_vec++;
        if (data_ok_o !== 1'b1 || inst_ok_o !== 1'b0 || inst_stall_o !== 1'b1) begin
            n_err++;
            $display("FAIL simul_data_ok: got dok %b iok %b istall %b expected 1 0 1",
                     data_ok_o, inst_ok_o, inst_stall_o);
        end
        bus_data_ok_i = 1'b0;
        data_req_i    = 1'b0;
        data_we_i     = 1'b0;
        tick(); // IDLE, grants inst
        n_vec++;
        if (bus_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL simul_idle: got req %b expected 0", bus_req_o);
        end
        tick(); // REQ for inst
        n_vec++;
        if ({bus_req_o, bus_wr_o, bus_wstrb_o} !== 6'b10_1111 ||
            bus_addr_o !== 32'h0000_0100 || bus_wdata_o !== 32'h0) begin
            n_err++;
            $display("FAIL simul_inst_req: got req %b wr %b wstrb %b addr %h wdata %h expected 1 0 1111 00000100 0",
                     bus_req_o, bus_wr_o, bus_wstrb_o, bus_addr_o, bus_wdata_o);
        end
        bus_addr_ok_i = 1'b1;
        tick();
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b1;
        bus_rdata_i   = 32'h1234_5678;
        tick();
        n_vec++;
        if (inst_ok_o !== 1'b1 || inst_rdata_o !== 32'h1234_5678 || data_ok_o !== 1'b0) begin
            n_err++;
            $display("FAIL simul_inst_ok: got iok %b rdata %h dok %b expected 1 12345678 0",
                     inst_ok_o, inst_rdata_o, data_ok_o);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_same_cycle();
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_sel_i   = 4'b0011;
        data_addr_i  = 32'h3000_0000;
        data_wdata_i = 32'h0000_5A5A;
        tick(); // REQ
        n_vec++;
        if ({bus_req_o, bus_wr_o, bus_wstrb_o} !== 6'b11_0011 || bus_wdata_o !== 32'h0000_5A5A) begin
            n_err++;
            $display("FAIL same_req: got req %b wr %b wstrb %b wdata %h expected 1 1 0011 00005a5a",
                     bus_req_o, bus_wr_o, bus_wstrb_o, bus_wdata_o);
        end
        bus_addr_ok_i = 1'b1;
        bus_data_ok_i = 1'b1;
        bus_rdata_i   = 32'h1111_2222;
        tick(); // DONE directly
        n_vec++;
        if (data_ok_o !== 1'b1 || data_rdata_o !== 32'h1111_2222 || bus_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL same_done: got ok %b rdata %h req %b expected 1 11112222 0",
                     data_ok_o, data_rdata_o, bus_req_o);
        end
        clear_inputs();
        tick();
        n_vec++;
        if (data_ok_o !== 1'b0) begin
            n_err++;
            $display("FAIL same_pulse: got %b expected 0", data_ok_o);
        end
    endtask

    task automatic test_starvation();
        logic [9:0] owners;
        int         grants;
        owners      = '0;
        grants      = 0;
        inst_req_i  = 1'b1;
        inst_addr_i = 32'h0000_0800;
        data_req_i  = 1'b1;
        data_sel_i  = 4'b1111;
        data_addr_i = 32'h2000_0000;
        for (int cyc = 0; cyc < 100 && grants < 10; cyc++) begin
            tick();
            if (bus_req_o === 1'b1) begin
                owners[grants] = (bus_addr_o == 32'h0000_0800);
                grants++;
                bus_addr_ok_i = 1'b1;
                bus_data_ok_i = 1'b1;
                bus_rdata_i   = 32'(grants);
            end else begin
                bus_addr_ok_i = 1'b0;
                bus_data_ok_i = 1'b0;
            end
        end
        tick();
        clear_inputs();
        tick();
        n_vec++;
        if (grants != 10) begin
            n_err++;
            $display("FAIL starve_timeout: got %0d grants expected 10", grants);
        end
        n_vec++;
        if (owners !== 10'b10_0001_0000) begin
            n_err++;
            $display("FAIL starve_order: got %b expected 1000010000 (bit i = grant i is inst)", owners);
        end
    endtask

    task automatic test_flush();
        inst_req_i  = 1'b1;
        inst_addr_i = 32'h0000_0300;
        tick(); // REQ
        n_vec++;
        if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h0000_0300) begin
            n_err++;
            $display("FAIL flush_req: got req %b addr %h expected 1 00000300", bus_req_o, bus_addr_o);
        end
        bus_addr_ok_i = 1'b1;
        tick(); // WAIT
        bus_addr_ok_i = 1'b0;
        flush_i       = 1'b1;
        tick(); // still WAIT
        flush_i       = 1'b0;
        bus_data_ok_i = 1'b1;
        bus_rdata_i   = 32'h0000_CAFE;
        inst_addr_i   = 32'h0000_0400;
        tick(); // DONE, fetch discarded
        n_vec++;
        if (inst_ok_o !== 1'b0 || inst_rdata_o !== 32'h0) begin
            n_err++;
            $display("FAIL flush_suppress: got ok %b rdata %h expected 0 0", inst_ok_o, inst_rdata_o);
        end
        bus_data_ok_i = 1'b0;
        bus_rdata_i   = '0;
        tick(); // IDLE, grants new fetch
        tick(); // REQ
        n_vec++;
        if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h0000_0400) begin
            n_err++;
            $display("FAIL flush_regrant: got req %b addr %h expected 1 00000400", bus_req_o, bus_addr_o);
        end
        bus_addr_ok_i = 1'b1;
        bus_data_ok_i = 1'b1;
        bus_rdata_i   = 32'h0000_4444;
        tick(); // DONE
        n_vec++;
        if (inst_ok_o !== 1'b1 || inst_rdata_o !== 32'h0000_4444) begin
            n_err++;
            $display("FAIL flush_next_ok: got ok %b rdata %h expected 1 00004444", inst_ok_o, inst_rdata_o);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_spurious();
        bus_addr_ok_i = 1'b1;
        bus_data_ok_i = 1'b1;
        bus_rdata_i   = 32'h5555_AAAA;
        tick();
        clear_inputs();
        tick();
        n_vec++;
        if ({inst_ok_o, data_ok_o, bus_req_o, bus_err_o} !== 4'b0000) begin
            n_err++;
            $display("FAIL spurious_idle: got iok %b dok %b req %b err %b expected 0000",
                     inst_ok_o, data_ok_o, bus_req_o, bus_err_o);
        end
    endtask

    task automatic test_reset_mid();
        // Reset in WAIT abandons the load: a late data_ok must not complete it.
        data_req_i  = 1'b1;
        data_sel_i  = 4'b1111;
        data_addr_i = 32'h5000_0000;
        tick();
        bus_addr_ok_i = 1'b1;
        tick(); // WAIT
        bus_addr_ok_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({bus_req_o, data_ok_o, inst_ok_o, bus_err_o} !== 4'b0000 || bus_addr_o !== 32'h0) begin
            n_err++;
            $display("FAIL reset_wait: got req %b dok %b iok %b err %b addr %h expected 0",
                     bus_req_o, data_ok_o, inst_ok_o, bus_err_o, bus_addr_o);
        end
        data_req_i = 1'b0;
        tick();
        rst           = 1'b1;
        bus_data_ok_i = 1'b1;
        bus_rdata_i   = 32'h7777_7777;
        tick();
        n_vec++;
        if (data_ok_o !== 1'b0 || data_rdata_o !== 32'h0) begin
            n_err++;
            $display("FAIL reset_abandon: got ok %b rdata %h expected 0 0", data_ok_o, data_rdata_o);
        end
        clear_inputs();
        tick();

        // Reset while ok_o is high must clear it without waiting for a clock.
        data_req_i  = 1'b1;
        data_sel_i  = 4'b1111;
        data_addr_i = 32'h6000_0000;
        tick();
        bus_addr_ok_i = 1'b1;
        bus_data_ok_i = 1'b1;
        bus_rdata_i   = 32'h9999_0000;
        tick(); // DONE
        clear_inputs();
        n_vec++;
        if (data_ok_o !== 1'b1 || data_rdata_o !== 32'h9999_0000) begin
            n_err++;
            $display("FAIL reset_pre: got ok %b rdata %h expected 1 99990000", data_ok_o, data_rdata_o);
        end
        #1;
        rst = 1'b0;
        #1;
        n_vec++;
        if (data_ok_o !== 1'b0 || data_rdata_o !== 32'h0) begin
            n_err++;
            $display("FAIL reset_async: got ok %b rdata %h expected 0 0", data_ok_o, data_rdata_o);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_simultaneous();
        test_same_cycle();
        test_starvation();
        test_flush();
        test_spurious();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
